// File: rtl/img_map_engine.sv
// img_map_engine: remaps every pixel of an image through a LUT, LANES lines
// at a time. Optional feature macro: IMG_MAP_IDENT_EN (adds bypass input).
// Ports: clk, reset (sync, active-high); start/busy/done control;
//   inp_rd_addr/inp_rd_data and lut_rd_addr/lut_rd_data, one slice per lane;
//   out_wt_en/out_wt_ready/out_wt_addr/out_wt_data line write port.
module img_map_engine #(
  parameter int PIX_W     = 8,
  parameter int WORD_W    = 128,
  parameter int LANES     = 2,
  parameter int NUM_LINES = 64,
  parameter int RD_LAT    = 2,
  parameter int ADDR_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
`ifdef IMG_MAP_IDENT_EN
  input  logic                      bypass,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [LANES*ADDR_W-1:0]   inp_rd_addr,
  input  logic [LANES*WORD_W-1:0]   inp_rd_data,
  output logic [LANES*ADDR_W-1:0]   lut_rd_addr,
  input  logic [LANES*WORD_W-1:0]   lut_rd_data,
  output logic                      out_wt_en,
  input  logic                      out_wt_ready,
  output logic [ADDR_W-1:0]         out_wt_addr,
  output logic [WORD_W-1:0]         out_wt_data
);

  localparam int P  = WORD_W / PIX_W;
  localparam int KW = (P > 1) ? $clog2(P) : 1;
  localparam int CW = $clog2(RD_LAT + 1);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {
    IDLE, LINE_RD, LINE_WAIT, PIX_IDX,
    LUT_WAIT, PIX_MAP, WRITE, DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] base_nx;
  logic [KW-1:0]     k;
  logic [CW-1:0]     cnt;
  logic [LW-1:0]     wl;
  logic [LW-1:0]     wsel;
  logic [WORD_W-1:0] wsel_data;
  logic [WORD_W-1:0] words [LANES];
  logic [WORD_W-1:0] acc   [LANES];
  logic [1:0]        slot  [LANES];
  logic [PIX_W-1:0]  pix_v [LANES];
  logic [PIX_W-1:0]  map_v [LANES];
  logic              byp_q;
  logic              wait_last;
  logic              k_last;
  logic              wl_last;
  logic              img_last;
  logic              wr_fire;

  assign base_nx   = base + ADDR_W'(LANES);
  assign wait_last = (cnt == CW'(RD_LAT - 1));
  assign k_last    = (k == KW'(P - 1));
  assign wl_last   = (wl == LW'(LANES - 1));
  assign img_last  = (base_nx == ADDR_W'(NUM_LINES));
  assign wr_fire   = out_wt_en & out_wt_ready;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  // While a write is pending the next lane's word is preloaded on accept.
  assign wsel = out_wt_en ? wl + LW'(1) : wl;

  always_comb begin
    wsel_data = '0;
    for (int n = 0; n < LANES; n++)
      if (wsel == LW'(n)) wsel_data = acc[n];
  end

  // Current pixel per lane, and its mapped value from the LUT slot.
  always_comb begin
    for (int n = 0; n < LANES; n++) begin
      pix_v[n] = PIX_W'(words[n] >> (k * PIX_W));
      map_v[n] = PIX_W'(lut_rd_data[n*WORD_W +: WORD_W] >> (slot[n] * 32));
    end
  end

`ifdef IMG_MAP_IDENT_EN
  always_ff @(posedge clk) begin
    if (reset)
      byp_q <= 1'b0;
    else if (state_q == IDLE && start)
      byp_q <= bypass;
  end
`else
  assign byp_q = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start) state_d = LINE_RD;
      LINE_RD:   state_d = LINE_WAIT;
      LINE_WAIT: if (wait_last) state_d = byp_q ? WRITE : PIX_IDX;
      PIX_IDX:   state_d = LUT_WAIT;
      LUT_WAIT:  if (wait_last) state_d = PIX_MAP;
      PIX_MAP:   state_d = k_last ? WRITE : PIX_IDX;
      WRITE:
        if (wr_fire && wl_last)
          state_d = img_last ? DONE : LINE_RD;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base        <= '0;
      k           <= '0;
      cnt         <= '0;
      wl          <= '0;
      inp_rd_addr <= '0;
      lut_rd_addr <= '0;
      out_wt_en   <= 1'b0;
      out_wt_addr <= '0;
      out_wt_data <= '0;
      for (int n = 0; n < LANES; n++) begin
        words[n] <= '0;
        acc[n]   <= '0;
        slot[n]  <= '0;
      end
    end else begin
      if ((state_q == LINE_WAIT || state_q == LUT_WAIT) && !wait_last)
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;

      case (state_q)
        IDLE: begin
          // Address is live during LINE_RD, so load it on entry.
          if (start)
            for (int n = 0; n < LANES; n++)
              inp_rd_addr[n*ADDR_W +: ADDR_W] <= ADDR_W'(n);
        end
        LINE_WAIT: begin
          if (wait_last) begin
            k <= '0;
            for (int n = 0; n < LANES; n++) begin
              words[n] <= inp_rd_data[n*WORD_W +: WORD_W];
              acc[n]   <= byp_q ? inp_rd_data[n*WORD_W +: WORD_W] : '0;
            end
          end
        end
        PIX_IDX: begin
          for (int n = 0; n < LANES; n++) begin
            lut_rd_addr[n*ADDR_W +: ADDR_W] <= ADDR_W'(pix_v[n] >> 2);
            slot[n] <= pix_v[n][1:0];
          end
        end
        PIX_MAP: begin
          for (int n = 0; n < LANES; n++)
            acc[n] <= acc[n] | (WORD_W'(map_v[n]) << (k * PIX_W));
          if (!k_last) k <= k + KW'(1);
        end
        WRITE: begin
          if (!out_wt_en) begin
            out_wt_en   <= 1'b1;
            out_wt_addr <= base + ADDR_W'(wl);
            out_wt_data <= wsel_data;
          end else if (out_wt_ready) begin
            if (wl_last) begin
              out_wt_en <= 1'b0;
              wl        <= '0;
              base      <= img_last ? '0 : base_nx;
              if (!img_last)
                for (int n = 0; n < LANES; n++)
                  inp_rd_addr[n*ADDR_W +: ADDR_W] <= base_nx + ADDR_W'(n);
            end else begin
              wl          <= wl + LW'(1);
              out_wt_addr <= base + ADDR_W'(wl) + ADDR_W'(1);
              out_wt_data <= wsel_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_img_map_engine.sv
// tb_img_map_engine: scoreboard bench for img_map_engine (default build and
// LANES=1/RD_LAT=3/NUM_LINES=4 build; bypass runs under IMG_MAP_IDENT_EN).
module tb_img_map_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         start0 = 1'b0;
  logic         ready0 = 1'b0;
  logic         busy0, done0, out_wt_en0;
  logic [31:0]  inp_rd_addr0, lut_rd_addr0;
  logic [255:0] inp_rd_data0, lut_rd_data0;
  logic [15:0]  out_wt_addr0;
  logic [127:0] out_wt_data0;

  logic         start1 = 1'b0;
  logic         ready1 = 1'b1;
  logic         busy1, done1, out_wt_en1;
  logic [15:0]  inp_rd_addr1, lut_rd_addr1;
  logic [127:0] inp_rd_data1, lut_rd_data1;
  logic [15:0]  out_wt_addr1;
  logic [127:0] out_wt_data1;

`ifdef IMG_MAP_IDENT_EN
  logic bypass0 = 1'b0;
`endif

  int mode = 0;
  bit inv = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt0 = 0, done_cnt0 = 0;
  int wr_cnt1 = 0, done_cnt1 = 0;
  bit saw1 = 1'b0;
  bit lut_nz = 1'b0;
  logic [143:0] q0[$];
  logic [143:0] q1[$];

  img_map_engine dut0 (
    .clk(clk), .reset(reset), .start(start0),
`ifdef IMG_MAP_IDENT_EN
    .bypass(bypass0),
`endif
    .busy(busy0), .done(done0),
    .inp_rd_addr(inp_rd_addr0), .inp_rd_data(inp_rd_data0),
    .lut_rd_addr(lut_rd_addr0), .lut_rd_data(lut_rd_data0),
    .out_wt_en(out_wt_en0), .out_wt_ready(ready0),
    .out_wt_addr(out_wt_addr0), .out_wt_data(out_wt_data0)
  );

  img_map_engine #(
    .LANES(1), .RD_LAT(3), .NUM_LINES(4)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1),
`ifdef IMG_MAP_IDENT_EN
    .bypass(1'b0),
`endif
    .busy(busy1), .done(done1),
    .inp_rd_addr(inp_rd_addr1), .inp_rd_data(inp_rd_data1),
    .lut_rd_addr(lut_rd_addr1), .lut_rd_data(lut_rd_data1),
    .out_wt_en(out_wt_en1), .out_wt_ready(ready1),
    .out_wt_addr(out_wt_addr1), .out_wt_data(out_wt_data1)
  );

  function automatic logic [7:0] pix(input logic [15:0] a, input int j);
    if (mode == 0) return 8'((a * 37) + (j * 11) + 3);
    return (a == 16'd0 && j == 0) ? 8'h05 : 8'h00;
  endfunction

  function automatic logic [7:0] fmap(input logic [7:0] v);
    return inv ? (8'hFF - v) : v;
  endfunction

  function automatic logic [127:0] in_word(input logic [15:0] a);
    logic [127:0] w;
    for (int j = 0; j < 16; j++) w[j*8 +: 8] = pix(a, j);
    return w;
  endfunction

  function automatic logic [127:0] exp_word(input logic [15:0] a,
                                            input bit byp);
    logic [127:0] w;
    for (int j = 0; j < 16; j++)
      w[j*8 +: 8] = byp ? pix(a, j) : fmap(pix(a, j));
    return w;
  endfunction

  // Each 32-bit entry carries junk above the pixel field.
  function automatic logic [127:0] lut_word(input logic [15:0] a);
    logic [127:0] w;
    for (int s = 0; s < 4; s++)
      w[s*32 +: 32] = {24'hA5A5A5, fmap(8'((a * 4) + s))};
    return w;
  endfunction

  // Memories: data(t) reflects address(t - RD_LAT).
  logic [31:0] ia0_a, la0_a;
  logic [15:0] ia1_a, ia1_b, la1_a, la1_b;
  always @(posedge clk) begin
    ia0_a <= inp_rd_addr0;
    la0_a <= lut_rd_addr0;
    inp_rd_data0 <= {in_word(ia0_a[31:16]), in_word(ia0_a[15:0])};
    lut_rd_data0 <= {lut_word(la0_a[31:16]), lut_word(la0_a[15:0])};
    ia1_a <= inp_rd_addr1;
    ia1_b <= ia1_a;
    la1_a <= lut_rd_addr1;
    la1_b <= la1_a;
    inp_rd_data1 <= in_word(ia1_b);
    lut_rd_data1 <= lut_word(la1_b);
  end

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [143:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
        if (lut_rd_addr0[15:0] == 16'd1) saw1 = 1'b1;
        if (lut_rd_addr0 != 32'd0) lut_nz = 1'b1;
        if (out_wt_en0 && ready0) begin
          wr_cnt0++;
          if (q0.size() == 0) begin
            check("wr0_extra", 128'(q0.size()), 128'd1);
          end else begin
            e = q0.pop_front();
            check("wr0_addr", 128'(out_wt_addr0), 128'(e[143:128]));
            check("wr0_data", out_wt_data0, e[127:0]);
          end
        end
        if (out_wt_en1 && ready1) begin
          wr_cnt1++;
          if (q1.size() == 0) begin
            check("wr1_extra", 128'(q1.size()), 128'd1);
          end else begin
            e = q1.pop_front();
            check("wr1_addr", 128'(out_wt_addr1), 128'(e[143:128]));
            check("wr1_data", out_wt_data1, e[127:0]);
          end
        end
      end
    end
  end

  task automatic run0(input bit stall, input bit byp);
    int n;
    wr_cnt0 = 0;
    done_cnt0 = 0;
    for (int l = 0; l < 64; l++)
      q0.push_back({16'(l), exp_word(16'(l), byp)});
    ready0 = !stall;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    if (stall) begin
      n = 0;
      while (!out_wt_en0 && n < 1000) begin tick; n++; end
      check("stall_en_seen", 128'(out_wt_en0), 128'd1);
      repeat (5) begin
        tick;
        check("stall_en", 128'(out_wt_en0), 128'd1);
        check("stall_addr", 128'(out_wt_addr0), 128'd0);
        check("stall_data", out_wt_data0, exp_word(16'd0, byp));
      end
      check("stall_no_wr", 128'(wr_cnt0), 128'd0);
      ready0 = 1'b1;
    end
    n = 0;
    while (done_cnt0 == 0 && n < 6000) begin tick; n++; end
    repeat (2) tick;
    check("done_pulse", 128'(done_cnt0), 128'd1);
    check("wr_count", 128'(wr_cnt0), 128'd64);
    check("sb_empty", 128'(q0.size()), 128'd0);
    check("idle_busy", 128'(busy0), 128'd0);
  endtask

  initial begin
    int n;
    int cyc;
    reset = 1'b1;
    repeat (3) tick;
    check("rst_busy", 128'(busy0), 128'd0);
    check("rst_done", 128'(done0), 128'd0);
    check("rst_en", 128'(out_wt_en0), 128'd0);
    check("rst_inp_addr", 128'(inp_rd_addr0), 128'd0);
    check("rst_lut_addr", 128'(lut_rd_addr0), 128'd0);
    check("rst_out_addr", 128'(out_wt_addr0), 128'd0);
    check("rst_out_data", out_wt_data0, 128'd0);
    check("rst_busy1", 128'(busy1), 128'd0);
    check("rst_inp_addr1", 128'(inp_rd_addr1), 128'd0);
    reset = 1'b0;
    tick;

`ifdef IMG_MAP_IDENT_EN
    mode = 0; inv = 1'b1; bypass0 = 1'b1; lut_nz = 1'b0;
    run0(1'b0, 1'b1);
    check("byp_lut_zero", 128'(lut_nz), 128'd0);
    bypass0 = 1'b0;
`endif

    // identity LUT, patterned lines
    mode = 0; inv = 1'b0;
    run0(1'b0, 1'b0);

    // inverting LUT, zero image with one 0x05 pixel, stalled first write
    mode = 1; inv = 1'b1; saw1 = 1'b0;
    run0(1'b1, 1'b0);
    check("lut_addr_1", 128'(saw1), 128'd1);

    // reset in LUT_WAIT of line 10, then a clean restart
    mode = 0; inv = 1'b1;
    wr_cnt0 = 0; done_cnt0 = 0; ready0 = 1'b1;
    for (int l = 0; l < 64; l++)
      q0.push_back({16'(l), exp_word(16'(l), 1'b0)});
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    n = 0;
    while (wr_cnt0 < 10 && n < 3000) begin tick; n++; end
    check("abort_reach", 128'(wr_cnt0), 128'd10);
    repeat (4) tick;
    reset = 1'b1;
    tick;
    check("abort_busy", 128'(busy0), 128'd0);
    check("abort_done", 128'(done0), 128'd0);
    check("abort_en", 128'(out_wt_en0), 128'd0);
    check("abort_inp_addr", 128'(inp_rd_addr0), 128'd0);
    check("abort_lut_addr", 128'(lut_rd_addr0), 128'd0);
    check("abort_out_addr", 128'(out_wt_addr0), 128'd0);
    check("abort_out_data", out_wt_data0, 128'd0);
    q0.delete();
    tick;
    reset = 1'b0;
    repeat (30) tick;
    check("abort_no_wr", 128'(wr_cnt0), 128'd10);
    check("abort_no_done", 128'(done_cnt0), 128'd0);
    run0(1'b0, 1'b0);

    // narrow build: 1 lane, RD_LAT=3, 4 lines, restart attempt mid-run
    mode = 0; inv = 1'b1;
    wr_cnt1 = 0; done_cnt1 = 0;
    for (int l = 0; l < 4; l++)
      q1.push_back({16'(l), exp_word(16'(l), 1'b0)});
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 3000) begin
      start1 = (cyc == 100);
      tick;
      cyc++;
    end
    start1 = 1'b0;
    check("d1_done", 128'(done1), 128'd1);
    check("d1_latency_min", 128'(cyc >= 345), 128'd1);
    tick;
    check("d1_done_1cyc", 128'(done1), 128'd0);
    check("d1_idle", 128'(busy1), 128'd0);
    repeat (20) tick;
    check("d1_no_restart", 128'(busy1), 128'd0);
    check("d1_wr_count", 128'(wr_cnt1), 128'd4);
    check("d1_done_count", 128'(done_cnt1), 128'd1);
    check("d1_sb_empty", 128'(q1.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
